// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and width limit for the bit-serial adder
package serial_adder_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: one-bit combinational add slice used as the serial datapath
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add sequenced LSB first through one full_adder slice
// SERIAL_ADDER_SUB_EN adds a sub port selecting a - b (cout=1 means no borrow)
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH must be in 1..%0d", MAX_WIDTH);
  end
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, b_in, sum_next;
  logic [CW-1:0] cnt;
  logic carry, c_in, fa_sum, fa_cout;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  // new sum bit enters at the MSB so the result is aligned after WIDTH shifts
  assign sum_next  = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum       = sum_sr;
  assign cout      = carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sr  <= a;
        b_sr  <= b_in;
        carry <= c_in;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_next;
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      state  <= cnt == CW'(WIDTH - 1) ? DONE : RUN;
    end else begin
      state <= out_ready ? IDLE : state;
    end
  end
endmodule
